wash_mode_ctrl: RTL and testbench

- Parametrised, clocked mode-selection controller for the washing-machine front panel.
- Tracks power/select/run phases and steps a mode index with next/prev buttons, wrapping at the ends.
- Locks the mode while a wash cycle runs and returns to selection on finish.
- Feeds the selected mode to the wash sequencer and the panel display.

---
 rtl/wash_mode_ctrl_if.sv | 23 ++
 rtl/wash_mode_ctrl.sv | 105 ++++++++++
 tb/tb_wash_mode_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/wash_mode_ctrl_if.sv
// Front-panel bus between the panel/sequencer side (master) and wash_mode_ctrl (slave).
interface wash_mode_ctrl_if #(
  parameter int MODE_W = 3
);
  logic              power_light;
  logic              start_light;
  logic              finish;
  logic              mode_next;
  logic              mode_prev;
  logic [MODE_W-1:0] current_mode;
  logic              running;
  logic              mode_changed;

  modport master (
    output power_light, start_light, finish, mode_next, mode_prev,
    input  current_mode, running, mode_changed
  );

  modport slave (
    input  power_light, start_light, finish, mode_next, mode_prev,
    output current_mode, running, mode_changed
  );
endinterface

// File: rtl/wash_mode_ctrl.sv
// Washing-machine mode selector: power/select/run phases, wrapping mode stepping.
// Optional macro MODE_MEMORY_EN: finish keeps the last run mode instead of DEFAULT_MODE.
//
// state    | meaning
// S_OFF    | machine unpowered, mode forced to 0
// S_SELECT | powered, mode stepped by next/prev button edges
// S_RUN    | wash cycle active, mode locked until finish or power loss
module wash_mode_ctrl #(
  parameter int NUM_MODES    = 5,
  parameter int MODE_W       = 3,
  parameter int DEFAULT_MODE = 1
) (
  input  logic             clk,
  input  logic             rst,
  wash_mode_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_OFF, S_SELECT, S_RUN} state_t;

  localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(NUM_MODES);
  localparam logic [MODE_W-1:0] MODE_DEF = MODE_W'(DEFAULT_MODE);
  localparam logic [MODE_W-1:0] MODE_ONE = MODE_W'(1);

  state_t            state_q, state_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              running_q, changed_q;
  logic              next_q, prev_q;
  logic              rearm_q, rearm_d;
  logic              next_edge, prev_edge;

  assign next_edge = bus.mode_next & ~next_q;
  assign prev_edge = bus.mode_prev & ~prev_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    // Rearm latches once start_light has been seen low; cleared on leaving RUN via finish.
    rearm_d = rearm_q | ~bus.start_light;
    case (state_q)
      S_OFF: begin
        mode_d  = '0;
        rearm_d = 1'b1;
        if (bus.power_light) begin
          state_d = S_SELECT;
          mode_d  = MODE_DEF;
        end
      end
      S_SELECT: begin
        if (!bus.power_light) begin
          state_d = S_OFF;
          mode_d  = '0;
        end else if (bus.start_light && rearm_q) begin
          state_d = S_RUN;
        end else if (next_edge && !prev_edge) begin
          mode_d = (mode_q == MODE_MAX) ? MODE_ONE : mode_q + MODE_ONE;
        end else if (prev_edge && !next_edge) begin
          mode_d = (mode_q == MODE_ONE) ? MODE_MAX : mode_q - MODE_ONE;
        end
      end
      S_RUN: begin
        if (!bus.power_light) begin
          state_d = S_OFF;
          mode_d  = '0;
        end else if (bus.finish) begin
          state_d = S_SELECT;
          rearm_d = 1'b0;
`ifdef MODE_MEMORY_EN
          mode_d  = mode_q;
`else
          mode_d  = MODE_DEF;
`endif
        end
      end
      default: begin
        state_d = S_OFF;
        mode_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_OFF;
      mode_q    <= '0;
      running_q <= 1'b0;
      changed_q <= 1'b0;
      next_q    <= 1'b0;
      prev_q    <= 1'b0;
      rearm_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      running_q <= (state_d == S_RUN);
      changed_q <= (mode_d != mode_q);
      next_q    <= bus.mode_next;
      prev_q    <= bus.mode_prev;
      rearm_q   <= rearm_d;
    end
  end

  assign bus.current_mode = mode_q;
  assign bus.running      = running_q;
  assign bus.mode_changed = changed_q;

endmodule

// File: tb/tb_wash_mode_ctrl.sv
// Directed table-driven bench for wash_mode_ctrl (NUM_MODES=5, DEFAULT_MODE=1).
module tb_wash_mode_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wash_mode_ctrl_if #(.MODE_W(3)) bus ();

  wash_mode_ctrl #(.NUM_MODES(5), .MODE_W(3), .DEFAULT_MODE(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef MODE_MEMORY_EN
  localparam logic [2:0] FM = 3'd3;
`else
  localparam logic [2:0] FM = 3'd1;
`endif
  localparam logic FCHG = (FM != 3'd3);

  typedef struct {
    logic r, p, s, f, n, v;
    logic [2:0] m;
    logic run, chg;
    string name;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  function automatic void add(input logic r, p, s, f, n, v, input logic [2:0] m,
                              input logic run, chg, input string name);
    vec_t t;
    t.r = r; t.p = p; t.s = s; t.f = f; t.n = n; t.v = v;
    t.m = m; t.run = run; t.chg = chg; t.name = name;
    vecs.push_back(t);
  endfunction

  task automatic step(input logic r, p, s, f, n, v, input logic [2:0] m,
                      input logic run, chg, input string name);
    @(negedge clk);
    rst = r;
    bus.power_light = p; bus.start_light = s; bus.finish = f;
    bus.mode_next = n;   bus.mode_prev = v;
    @(posedge clk);
    #1;
    total++;
    if ({bus.current_mode, bus.running, bus.mode_changed} !== {m, run, chg}) begin
      bad++;
      $display("FAIL %s: got mode=%0d run=%0b chg=%0b, want mode=%0d run=%0b chg=%0b",
               name, bus.current_mode, bus.running, bus.mode_changed, m, run, chg);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.power_light = 0; bus.start_light = 0; bus.finish = 0;
    bus.mode_next = 0;   bus.mode_prev = 0;

    //   r  p  s  f  n  v  mode run chg
    add(1, 0, 0, 0, 0, 0, 3'd0, 0, 0, "reset0");
    add(1, 0, 0, 0, 0, 0, 3'd0, 0, 0, "reset1");
    add(0, 1, 0, 0, 0, 0, 3'd1, 0, 1, "power_on");
    add(0, 1, 0, 0, 0, 0, 3'd1, 0, 0, "select_idle");
    add(0, 1, 0, 0, 1, 0, 3'd2, 0, 1, "next_2");
    add(0, 1, 0, 0, 0, 0, 3'd2, 0, 0, "rel");
    add(0, 1, 0, 0, 1, 0, 3'd3, 0, 1, "next_3");
    add(0, 1, 0, 0, 0, 0, 3'd3, 0, 0, "rel");
    add(0, 1, 0, 0, 1, 0, 3'd4, 0, 1, "next_4");
    add(0, 1, 0, 0, 0, 0, 3'd4, 0, 0, "rel");
    add(0, 1, 0, 0, 1, 0, 3'd5, 0, 1, "next_5");
    add(0, 1, 0, 0, 0, 0, 3'd5, 0, 0, "rel");
    add(0, 1, 0, 0, 1, 0, 3'd1, 0, 1, "next_wrap");
    add(0, 1, 0, 0, 0, 0, 3'd1, 0, 0, "rel");
    add(0, 1, 0, 0, 0, 1, 3'd5, 0, 1, "prev_wrap");
    add(0, 1, 0, 0, 0, 0, 3'd5, 0, 0, "rel");
    add(0, 1, 0, 0, 1, 1, 3'd5, 0, 0, "both_edges");
    add(0, 1, 0, 0, 0, 0, 3'd5, 0, 0, "rel");
    add(0, 1, 0, 0, 0, 1, 3'd4, 0, 1, "prev_4");
    add(0, 1, 0, 0, 0, 0, 3'd4, 0, 0, "rel");
    add(0, 1, 0, 0, 0, 1, 3'd3, 0, 1, "prev_3");
    add(0, 1, 0, 0, 0, 0, 3'd3, 0, 0, "rel");
    add(0, 1, 1, 0, 0, 0, 3'd3, 1, 0, "start_run");
    for (int k = 0; k < 4; k++) begin
      add(0, 1, 1, 0, 1, 0, 3'd3, 1, 0, "run_lock_press");
      add(0, 1, 1, 0, 0, 0, 3'd3, 1, 0, "run_lock_rel");
    end
    add(0, 1, 0, 0, 0, 0, 3'd3, 1, 0, "start_drop_stays_run");
    add(0, 1, 1, 1, 0, 0, FM,   0, FCHG, "finish_start_high");
    add(0, 1, 1, 0, 0, 0, FM,   0, 0, "no_rearm_1");
    add(0, 1, 1, 0, 0, 0, FM,   0, 0, "no_rearm_2");
    add(0, 1, 0, 0, 0, 0, FM,   0, 0, "start_low");
    add(0, 1, 1, 0, 0, 0, FM,   1, 0, "rerun");
    add(0, 0, 1, 0, 0, 0, 3'd0, 0, 1, "power_loss_run");
    add(0, 1, 1, 0, 0, 0, 3'd1, 0, 1, "power_on_again");
    add(0, 1, 1, 0, 0, 0, 3'd1, 1, 0, "run_again");
    add(0, 0, 1, 1, 0, 0, 3'd0, 0, 1, "off_beats_finish");
    add(0, 1, 0, 0, 0, 0, 3'd1, 0, 1, "power_on_3");
    add(0, 1, 1, 0, 0, 0, 3'd1, 1, 0, "run_3");
    add(1, 1, 1, 0, 0, 0, 3'd0, 0, 0, "rst_mid_run");
    add(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, "off_after_rst");
    add(0, 0, 0, 0, 1, 0, 3'd0, 0, 0, "off_press");
    add(0, 1, 0, 0, 1, 0, 3'd1, 0, 1, "held_power_on");
    add(0, 1, 0, 0, 1, 0, 3'd1, 0, 0, "held_no_step");
    add(0, 1, 0, 0, 0, 0, 3'd1, 0, 0, "held_release");
    add(0, 1, 0, 0, 1, 0, 3'd2, 0, 1, "repress");
    add(0, 1, 0, 1, 0, 0, 3'd2, 0, 0, "finish_in_select");

    foreach (vecs[i])
      step(vecs[i].r, vecs[i].p, vecs[i].s, vecs[i].f, vecs[i].n, vecs[i].v,
           vecs[i].m, vecs[i].run, vecs[i].chg, vecs[i].name);

    // Button held across reset, power applied on the first post-reset cycle.
    step(1, 0, 0, 0, 1, 0, 3'd0, 0, 0, "hold_rst");
    step(0, 1, 0, 0, 1, 0, 3'd1, 0, 1, "hold_rst_power");
    step(0, 1, 0, 0, 1, 0, 3'd1, 0, 0, "hold_rst_no_step");
    step(0, 1, 0, 0, 0, 1, 3'd5, 0, 1, "prev_after_hold");

    // Power drop straight from SELECT, then prev held through power-on.
    step(0, 0, 0, 0, 0, 1, 3'd0, 0, 1, "select_power_off");
    step(0, 1, 0, 0, 0, 1, 3'd1, 0, 1, "prev_held_power_on");
    step(0, 1, 0, 0, 0, 1, 3'd1, 0, 0, "prev_held_no_step");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
